// File: rtl/serial_pattern_gen_if.sv
// Stimulus-side bundle for serial_pattern_gen: frame request, pattern word and
// the registered serial stream with its status flags.
interface serial_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             repeat_en;
    logic             sout;
    logic             busy;
    logic             bit_tick;
    logic             done;

    modport master (
        output start, din, repeat_en,
        input  sout, busy, bit_tick, done
    );

    modport slave (
        input  start, din, repeat_en,
        output sout, busy, bit_tick, done
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Parallel-to-serial pattern source: shifts a captured word out MSB-first,
// holding each bit DIV cycles, with optional seamless frame repeat.
module serial_pattern_gen #(
    parameter int   WIDTH    = 8,
    parameter int   DIV      = 1,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_pattern_gen_if.slave  bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   word_q, word_d;
    // Holds only the bits still to be sent; the bit on sout lives in sout_q.
    logic [WIDTH-2:0]   shreg_q, shreg_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]      div_cnt_q, div_cnt_d;
    logic               sout_q, sout_d;
    logic               busy_q, busy_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            sout_q    <= IDLE_BIT;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            sout_q    <= sout_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sout_d    = sout_q;
        busy_d    = busy_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                sout_d = IDLE_BIT;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d   = SHIFT;
                    word_d    = bus.din;
                    shreg_d   = bus.din[WIDTH-2:0];
                    sout_d    = bus.din[WIDTH-1];
                    busy_d    = 1'b1;
                    tick_d    = 1'b1;
                    bit_cnt_d = BIT_MAX;
                    div_cnt_d = DIV_MAX;
                end
            end
            SHIFT: begin
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end else if (bit_cnt_q != '0) begin
                    sout_d    = shreg_q[WIDTH-2];
                    shreg_d   = shreg_q << 1;
                    tick_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    div_cnt_d = DIV_MAX;
                end else if (bus.repeat_en) begin
                    // Reload from the captured word so live din never leaks in.
                    sout_d    = word_q[WIDTH-1];
                    shreg_d   = word_q[WIDTH-2:0];
                    tick_d    = 1'b1;
                    bit_cnt_d = BIT_MAX;
                    div_cnt_d = DIV_MAX;
                end else begin
                    state_d = IDLE;
                    sout_d  = IDLE_BIT;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sout     = sout_q;
    assign bus.busy     = busy_q;
    assign bus.bit_tick = tick_q;
    assign bus.done     = done_q;
endmodule
